// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared state encoding and default sizing for the FIFO write
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

package fifo_arb_pkg;

    localparam int c_default_num_req   = 4;
    localparam int c_default_burst_len = 4;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker; the first requester at or
//               after i_ptr (wrapping modulo NUM_REQ) wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = c_default_num_req,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int w_dist;
    int w_best;

    // Rank each requester by its distance from the pointer; smallest wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_dist   = 0;
        w_best   = NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k >= int'(i_ptr)) ? (k - int'(i_ptr)) : (k + NUM_REQ - int'(i_ptr));
            if (i_req[k] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
                o_idx       = PTR_W'(k);
                o_any       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ valid/ready producers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = c_default_num_req,
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int BURST_LEN  = c_default_burst_len
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fifo_valid,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    input  logic                          i_fifo_ready,
    input  logic                          i_fifo_almostfull,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    localparam int c_ptr_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(BURST_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BURST_LEN - 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(NUM_REQ - 1);

    arb_state_t          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_busy;
    logic [c_cnt_w-1:0]  r_beat_cnt;
    logic [c_ptr_w-1:0]  r_rr_ptr;

    logic [NUM_REQ-1:0]    w_pick_onehot;
    logic [c_ptr_w-1:0]    w_pick_idx;
    logic                  w_pick_any;
    logic                  w_gnt_valid;
    logic                  w_beat;
    logic                  w_burst_end;
    logic                  w_arb_en;
    logic [DATA_WIDTH-1:0] w_fifo_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_picker (
        .i_req    (i_req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // r_grant is all-zero in IDLE, so the pass-through collapses to zero there.
    assign w_gnt_valid = |(i_req_valid & r_grant);
    assign w_beat      = w_gnt_valid & i_fifo_ready;
    assign w_burst_end = (r_state == ARB_BURST) &
                         (~w_gnt_valid | (w_beat & (r_beat_cnt == c_last_beat)));
    assign w_arb_en    = ((r_state == ARB_IDLE) | w_burst_end) & ~i_fifo_almostfull;

    always_comb begin
        w_fifo_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_fifo_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_fifo_valid = w_gnt_valid;
    assign o_fifo_data  = w_fifo_data;
    assign o_req_ready  = r_grant & {NUM_REQ{i_fifo_ready}};
    assign o_grant      = r_grant;
    assign o_busy       = r_busy;

    // Burst end and re-arbitration share a cycle, so back-to-back bursts have no bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else if (w_arb_en && w_pick_any) begin
            r_state    <= ARB_BURST;
            r_grant    <= w_pick_onehot;
            r_busy     <= 1'b1;
            r_beat_cnt <= '0;
            r_rr_ptr   <= (w_pick_idx == c_last_ptr) ? '0 : w_pick_idx + 1'b1;
        end else if ((r_state == ARB_IDLE) || w_burst_end) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter: directed tables and
//               sequences plus random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_valid;
    logic [DW-1:0]     fifo_data;
    logic              fifo_ready;
    logic              fifo_af;
    logic [N-1:0]      grant;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .o_req_ready       (req_ready),
        .o_fifo_valid      (fifo_valid),
        .o_fifo_data       (fifo_data),
        .i_fifo_ready      (fifo_ready),
        .i_fifo_almostfull (fifo_af),
        .o_grant           (grant),
        .o_busy            (busy)
    );

    typedef struct {
        logic [N-1:0] grant;
        logic         busy;
        logic         fvalid;
        logic [N-1:0] rdy;
    } obs_t;

    typedef struct {
        logic [N-1:0] v;
        logic         r;
        logic         af;
        obs_t         exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: granted producer (-1 = none), beats taken this burst,
    // next search start, and per-producer beat sequence numbers.
    int m_g;
    int m_cnt;
    int m_ptr;
    int seq[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pdata(input int k);
        return DW'(k * 64 + (seq[k] % 64));
    endfunction

    task automatic model_reset();
        m_g   = -1;
        m_cnt = 0;
        m_ptr = 0;
        for (int k = 0; k < N; k++) seq[k] = 0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        fifo_ready = 1'b0;
        fifo_af    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic [N-1:0] v, input logic r, input logic af, output obs_t o);
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_rdy;
        logic          e_fv;
        logic [DW-1:0] e_data;
        bit            beat;
        bit            bend;
        int            win;
        req_valid  = v;
        fifo_ready = r;
        fifo_af    = af;
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = pdata(k);
        #1;
        e_grant = '0;
        e_rdy   = '0;
        e_fv    = 1'b0;
        e_data  = '0;
        if (m_g >= 0) begin
            e_grant[m_g] = 1'b1;
            e_rdy[m_g]   = r;
            e_fv         = v[m_g];
            e_data       = pdata(m_g);
        end
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(m_g >= 0));
        chk("fifo_valid", 32'(fifo_valid), 32'(e_fv));
        chk("fifo_data", 32'(fifo_data), 32'(e_data));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        o.grant  = grant;
        o.busy   = busy;
        o.fvalid = fifo_valid;
        o.rdy    = req_ready;

        beat = (m_g >= 0) && v[m_g] && r;
        bend = (m_g >= 0) && (!v[m_g] || (beat && m_cnt == BL - 1));
        if (beat) seq[m_g]++;
        if ((m_g < 0 || bend) && !af) begin
            win = -1;
            for (int i = 0; i < N; i++) begin
                if (win < 0 && v[(m_ptr + i) % N]) win = (m_ptr + i) % N;
            end
            m_g = win;
            if (win >= 0) begin
                m_cnt = 0;
                m_ptr = (win + 1) % N;
            end
        end else if (m_g < 0 || bend) begin
            m_g = -1;
        end else if (beat) begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        obs_t o;
        vec_t tbl[12];
        int   beats;
        int   first_c;
        int   last_c;
        logic [N-1:0] gseq[5];

        // Reset state
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        fifo_ready = 1'b1;
        fifo_af    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fifo_valid", 32'(fifo_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_fifo_data", 32'(fifo_data), 32'h0);
        rst_n = 1'b1;

        // Single producer streams 10 beats: bursts 4,4,2 over 10 consecutive cycles
        do_reset();
        beats = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && beats < 10; c++) begin
            cycle(N'(1), 1'b1, 1'b0, o);
            if (o.fvalid && o.rdy[0]) begin
                beats++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        chk("t1_beats", 32'(beats), 32'd10);
        chk("t1_span", 32'(last_c - first_c + 1), 32'd10);
        cycle('0, 1'b1, 1'b0, o);

        // All producers valid: grant order 0,1,2,3,0 with 4 beats each, no gaps
        do_reset();
        beats = 0;
        for (int c = 0; c < 18; c++) begin
            cycle('1, 1'b1, 1'b0, o);
            if (c >= 1 && o.fvalid && (|o.rdy)) beats++;
            if (c >= 1 && ((c - 1) % 4 == 0)) gseq[(c - 1) / 4] = o.grant;
        end
        chk("t2_beats", 32'(beats), 32'd17);
        chk("t2_g0", 32'(gseq[0]), 32'h1);
        chk("t2_g1", 32'(gseq[1]), 32'h2);
        chk("t2_g2", 32'(gseq[2]), 32'h4);
        chk("t2_g3", 32'(gseq[3]), 32'h8);
        chk("t2_g4", 32'(gseq[4]), 32'h1);

        // Early release, almostfull at burst end, and stall: explicit table
        tbl[0]  = '{4'b0010, 1'b1, 1'b0, '{4'b0000, 1'b0, 1'b0, 4'b0000}};
        tbl[1]  = '{4'b1110, 1'b1, 1'b0, '{4'b0010, 1'b1, 1'b1, 4'b0010}};
        tbl[2]  = '{4'b1110, 1'b1, 1'b0, '{4'b0010, 1'b1, 1'b1, 4'b0010}};
        tbl[3]  = '{4'b1100, 1'b1, 1'b0, '{4'b0010, 1'b1, 1'b0, 4'b0010}};
        tbl[4]  = '{4'b1100, 1'b1, 1'b0, '{4'b0100, 1'b1, 1'b1, 4'b0100}};
        tbl[5]  = '{4'b1100, 1'b1, 1'b1, '{4'b0100, 1'b1, 1'b1, 4'b0100}};
        tbl[6]  = '{4'b1100, 1'b1, 1'b1, '{4'b0100, 1'b1, 1'b1, 4'b0100}};
        tbl[7]  = '{4'b1100, 1'b1, 1'b1, '{4'b0100, 1'b1, 1'b1, 4'b0100}};
        tbl[8]  = '{4'b1100, 1'b1, 1'b1, '{4'b0000, 1'b0, 1'b0, 4'b0000}};
        tbl[9]  = '{4'b1100, 1'b1, 1'b0, '{4'b0000, 1'b0, 1'b0, 4'b0000}};
        tbl[10] = '{4'b1100, 1'b1, 1'b0, '{4'b1000, 1'b1, 1'b1, 4'b1000}};
        tbl[11] = '{4'b1100, 1'b0, 1'b0, '{4'b1000, 1'b1, 1'b1, 4'b0000}};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].r, tbl[i].af, o);
            chk($sformatf("tbl%0d_grant", i), 32'(o.grant), 32'(tbl[i].exp.grant));
            chk($sformatf("tbl%0d_busy", i), 32'(o.busy), 32'(tbl[i].exp.busy));
            chk($sformatf("tbl%0d_fvalid", i), 32'(o.fvalid), 32'(tbl[i].exp.fvalid));
            chk($sformatf("tbl%0d_rdy", i), 32'(o.rdy), 32'(tbl[i].exp.rdy));
        end

        // FIFO not ready for 3 cycles mid-burst: burst still delivers exactly 4 beats
        do_reset();
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(4'b0011, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 1'b0, o);
            if (o.grant == 4'b0010) break;
            if (o.grant == 4'b0001 && o.fvalid && o.rdy[0]) beats++;
            if (c >= 2 && c <= 4) chk("t4_stall_rdy", 32'(o.rdy), 32'h0);
        end
        chk("t4_burst_beats", 32'(beats), 32'd4);

        // Asynchronous reset mid-burst, then first grant from index 0 upward
        do_reset();
        repeat (3) cycle('1, 1'b1, 1'b0, o);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_fifo_valid", 32'(fifo_valid), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(4'b1010, 1'b1, 1'b0, o);
        cycle(4'b1010, 1'b1, 1'b0, o);
        chk("arst_first_grant", 32'(o.grant), 32'h2);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle(N'($urandom), ($urandom % 4) != 0, ($urandom % 5) == 0, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `sync_fifo` write port among `NUM_REQ` producers.
- Each producer has a valid/ready/data interface; the winner is forwarded onto the FIFO's `i_valid_s`/`i_datain`/`o_ready_s` handshake in bursts of up to `BURST_LEN` beats.
- Sits directly in front of the FIFO write side, between the regional-maxima producer stages and the FIFO.
- Uses the FIFO's `o_almostfull` to stop new bursts from starting.

## Interface
- `NUM_REQ`, default 4: number of producers (≥2).
- `DATA_WIDTH`, default `` `CFG_DATA_WIDTH ``: beat width, equal to the FIFO's.
- `BURST_LEN`, default 4: maximum beats per grant (≥1).
- `i_clk`, in, 1: clock; single clock domain.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_req_valid`, in, `NUM_REQ`: per-producer beat valid.
- `i_req_data`, in, `NUM_REQ*DATA_WIDTH`: producer k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `o_req_ready`, out, `NUM_REQ`: per-producer accept; at most one bit high.
- `o_fifo_valid`, out, 1: drives FIFO `i_valid_s`.
- `o_fifo_data`, out, `DATA_WIDTH`: drives FIFO `i_datain`.
- `i_fifo_ready`, in, 1: from FIFO `o_ready_s`.
- `i_fifo_almostfull`, in, 1: from FIFO `o_almostfull`.
- `o_grant`, out, `NUM_REQ`: registered one-hot grant; all zero when no burst is active.
- `o_busy`, out, 1: high while in BURST.

## Operation
- FSM has two states.
  - IDLE: no grant.
  - BURST: `o_grant` selects producer g.
- Arbitration point: any cycle in IDLE, or the final cycle of a burst.
  - Candidates are producers with `i_req_valid` high.
  - Search starts at `rr_ptr` and wraps modulo `NUM_REQ`; the first candidate wins.
  - Arbitration is suppressed while `i_fifo_almostfull`=1. In that case the FSM stays in or returns to IDLE.
- Grant result is registered. On entry to BURST: `o_grant`=onehot(g), `beat_cnt`=0, `rr_ptr`=(g+1) mod `NUM_REQ`.
- In BURST the datapath is combinational pass-through:
  - `o_fifo_valid` = `i_req_valid[g]`
  - `o_fifo_data` = producer g's slice
  - `o_req_ready[g]` = `i_fifo_ready`; all other ready bits are 0.
- Beat: `o_fifo_valid & i_fifo_ready`; each beat increments `beat_cnt`.
- A burst ends in a cycle where either:
  - a beat occurs with `beat_cnt`=`BURST_LEN`-1, or
  - `i_req_valid[g]`=0 (the producer released early; no beat that cycle).
- At burst end the arbitration point applies in the same cycle: a winner gives BURST→BURST with the new grant, otherwise the FSM goes to IDLE. There is no bubble between back-to-back bursts.
- `i_fifo_almostfull` never truncates a burst in progress. `i_fifo_ready`=0 stalls the burst: `beat_cnt` holds and there is no timeout.
- In IDLE: `o_fifo_valid`=0, `o_req_ready`=0, `o_fifo_data`=0.
- Width rules:
  - `beat_cnt`: `$clog2(BURST_LEN+1)` bits.
  - `rr_ptr`: `$clog2(NUM_REQ)` bits.
  - Wrap is explicit at `NUM_REQ`-1→0, since `NUM_REQ` need not be a power of 2.

## Timing
- Reset values: state=IDLE, `o_grant`=0, `o_busy`=0, `rr_ptr`=0, `beat_cnt`=0. Combinational outputs follow, so `o_fifo_valid`=0, `o_req_ready`=0, `o_fifo_data`=0.
- Reset mid-burst: the burst is abandoned immediately and asynchronously. Beats already accepted by the FIFO stand; no partial-beat replay.
- Latency: a request seen in IDLE at cycle N gives grant and first possible beat at cycle N+1. Request-to-FIFO latency within a burst is 0 cycles.
- Throughput: one beat per cycle while the producer is valid and the FIFO is ready, including across burst boundaries.
- Handshake rule: producers hold data stable while valid and not ready. The arbiter never asserts ready to an ungranted producer.

## Structure
- Shared package `fifo_arb_pkg` holds the state enum (`ARB_IDLE`, `ARB_BURST`) and default `NUM_REQ`/`BURST_LEN` constants.
- Sub-module `rr_picker`: combinational round-robin priority picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot winner, winner index, and any-valid.
- Top level holds the FSM, counters and pass-through mux.

## Test plan
- Single producer 0 streams 10 beats, FIFO always ready → grants to 0 in bursts of 4, 4, 2. 10 beats reach the FIFO in order over 10 consecutive cycles.
- All 4 producers continuously valid → grant order 0,1,2,3,0. Each gets exactly 4 beats per turn, with no idle cycle between bursts.
- Producer 1 drops valid after 2 beats while 2 and 3 request → burst ends, next grant is 2 in the same cycle, `rr_ptr`=3 afterward.
- `i_fifo_ready` low for 3 cycles mid-burst → `beat_cnt` holds, ready is low to the producer, and the burst completes with exactly 4 beats.
- `i_fifo_almostfull`=1 at burst end with requests pending → FSM goes to IDLE with `o_grant`=0. The in-progress burst completes fully, and a new grant appears one cycle after almostfull clears.
- Assert `i_rst_n`=0 mid-burst → `o_grant`, `o_busy`, `o_fifo_valid` and `o_req_ready` go to 0 immediately. After release, the first grant goes to the lowest valid index starting from 0.
